// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types.
// FSM state and request opcode enums.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side and memory-side bus of the multi-port memory arbiter.
// slave = arbiter view, master = cores plus memory controller view.
interface mem_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);

    logic [NUM_PORTS-1:0]                 c_rd_req;
    logic [NUM_PORTS-1:0]                 c_wr_req;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] c_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] c_wr_data;
    logic [NUM_PORTS-1:0]                 c_busy;
    logic [NUM_PORTS-1:0]                 c_ack;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] c_rd_data;

    logic                  m_rd_req;
    logic                  m_wr_req;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wr_data;
    logic [DATA_WIDTH-1:0] m_rd_data;
    logic                  m_busy;
    logic                  m_ack;

    modport slave (
        input  c_rd_req, c_wr_req, c_addr, c_wr_data,
        output c_busy, c_ack, c_rd_data,
        output m_rd_req, m_wr_req, m_addr, m_wr_data,
        input  m_rd_data, m_busy, m_ack
    );

    modport master (
        output c_rd_req, c_wr_req, c_addr, c_wr_data,
        input  c_busy, c_ack, c_rd_data,
        input  m_rd_req, m_wr_req, m_addr, m_wr_data,
        output m_rd_data, m_busy, m_ack
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first pending port at or after ptr, with wrap.
// Purely combinational.
module rr_pick #(
    parameter  int NUM_PORTS = 4,
    localparam int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pend,
    input  logic [IW-1:0]        ptr,
    output logic [IW-1:0]        grant,
    output logic                 valid
);

    localparam int SW = IW + 1;

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin : scan
        logic [SW-1:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + SW'(k);
            if (idx >= SW'(NUM_PORTS))
                idx = idx - SW'(NUM_PORTS);
            if (pend[idx[IW-1:0]]) begin
                grant = idx[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one delayed memory among NUM_PORTS cores.
// One buffered request per port, one transaction in flight at a time.
module mem_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    import mem_arb_pkg::*;

    localparam int IW = $clog2(NUM_PORTS);

    state_t state, state_nx;

    logic [NUM_PORTS-1:0]                 pend;
    op_t                                  op_q [NUM_PORTS];
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_q;

    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        g_q;
    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic                 issue;
    logic                 done;
    logic [NUM_PORTS-1:0] clr;
    logic [NUM_PORTS-1:0] take;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .pend  (pend),
        .ptr   (rr_ptr),
        .grant (pick),
        .valid (pick_vld)
    );

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (pick_vld && !bus.m_busy) begin
                issue    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (bus.m_ack) begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A port may re-request on the edge its slot is freed.
    always_comb begin
        clr = '0;
        if (done)
            clr[g_q] = 1'b1;
        take = (bus.c_rd_req | bus.c_wr_req) & (~pend | clr);
    end

    assign bus.c_busy = pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++)
                op_q[i] <= OP_RD;
        end else begin
            pend <= (pend & ~clr) | take;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (take[i]) begin
                    op_q[i]    <= bus.c_wr_req[i] ? OP_WR : OP_RD;
                    addr_q[i]  <= bus.c_addr[i];
                    wdata_q[i] <= bus.c_wr_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            g_q           <= '0;
            bus.m_rd_req  <= 1'b0;
            bus.m_wr_req  <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_wr_data <= '0;
            bus.c_ack     <= '0;
            bus.c_rd_data <= '0;
        end else begin
            state        <= state_nx;
            bus.m_rd_req <= issue && (op_q[pick] == OP_RD);
            bus.m_wr_req <= issue && (op_q[pick] == OP_WR);
            bus.c_ack    <= clr;
            if (issue) begin
                g_q           <= pick;
                bus.m_addr    <= addr_q[pick];
                bus.m_wr_data <= wdata_q[pick];
            end
            if (done) begin
                rr_ptr <= (g_q == IW'(NUM_PORTS - 1)) ? '0 : g_q + 1'b1;
                bus.c_rd_data[g_q] <= (op_q[g_q] == OP_WR) ? '0 : bus.m_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    import mem_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: pending slots, pointer, transaction in flight
    logic [N-1:0]  mp;
    op_t           mop [N];
    logic [AW-1:0] ma  [N];
    logic [DW-1:0] md  [N];
    int            rr;
    int            infl;
    logic [N-1:0]  x_ack;
    logic [DW-1:0] x_rd;
    logic          x_iss;
    op_t           x_op;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wd;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wd;

    // memory emulator
    logic [DW-1:0] mem [256];
    int            cd;
    logic [7:0]    cur_a;
    op_t           cur_op;

    // stimulus and observations
    logic [N-1:0]  s_rd, s_wr;
    logic [AW-1:0] s_addr [N];
    logic [DW-1:0] s_wd   [N];
    int            lat;
    int            busy_pct;
    logic          force_busy;
    logic          inj_ack;
    logic [AW-1:0] iss_q [$];
    op_t           opq   [$];
    logic [DW-1:0] ack_data;
    int            n_ack;

    task automatic step();
        logic         ack_now;
        logic [N-1:0] nx_ack;
        int           g, idx;
        @(negedge clk);
        check("c_busy", bus.c_busy, mp);
        check("c_ack", bus.c_ack, x_ack);
        for (int i = 0; i < N; i++)
            if (x_ack[i]) check("c_rd_data", bus.c_rd_data[i], x_rd);
        check("m_req", {bus.m_wr_req, bus.m_rd_req},
              x_iss ? ((x_op == OP_WR) ? 2'b10 : 2'b01) : 2'b00);
        if (x_iss) begin
            last_addr = x_addr;
            last_wd   = x_wd;
        end
        check("m_addr", bus.m_addr, last_addr);
        check("m_wr_data", bus.m_wr_data, last_wd);
        for (int i = 0; i < N; i++)
            if (bus.c_ack[i]) begin
                n_ack++;
                ack_data = bus.c_rd_data[i];
            end
        ack_now = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                ack_now = 1'b1;
                cd = -1;
            end
        end
        if (bus.m_rd_req || bus.m_wr_req) begin
            iss_q.push_back(bus.m_addr);
            opq.push_back(bus.m_wr_req ? OP_WR : OP_RD);
            cur_a  = bus.m_addr[7:0];
            cur_op = bus.m_wr_req ? OP_WR : OP_RD;
            if (bus.m_wr_req) mem[cur_a] = bus.m_wr_data;
            cd = (lat > 0) ? lat : int'($urandom_range(1, 4));
        end
        bus.m_ack     = ack_now | inj_ack;
        bus.m_rd_data = (ack_now && cur_op == OP_RD) ? mem[cur_a] : DW'($urandom);
        bus.m_busy    = force_busy | ($urandom_range(0, 99) < busy_pct);
        bus.c_rd_req  = s_rd;
        bus.c_wr_req  = s_wr;
        for (int i = 0; i < N; i++) begin
            bus.c_addr[i]    = s_addr[i];
            bus.c_wr_data[i] = s_wd[i];
        end
        nx_ack = '0;
        x_iss  = 1'b0;
        if (infl >= 0 && bus.m_ack) begin
            nx_ack[infl] = 1'b1;
            x_rd = (mop[infl] == OP_WR) ? '0 : bus.m_rd_data;
            mp[infl] = 1'b0;
            rr   = (infl + 1) % N;
            infl = -1;
        end else if (infl < 0 && mp != '0 && !bus.m_busy) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && mp[idx]) g = idx;
            end
            x_iss  = 1'b1;
            x_op   = mop[g];
            x_addr = ma[g];
            x_wd   = md[g];
            infl   = g;
        end
        x_ack = nx_ack;
        for (int i = 0; i < N; i++)
            if ((s_rd[i] || s_wr[i]) && !mp[i]) begin
                mp[i]  = 1'b1;
                mop[i] = s_wr[i] ? OP_WR : OP_RD;
                ma[i]  = s_addr[i];
                md[i]  = s_wd[i];
            end
        s_rd    = '0;
        s_wr    = '0;
        inj_ack = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((mp != '0 || infl >= 0) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) check("drain_timeout", 1, 0);
        step();
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.c_rd_req  = '0;
        bus.c_wr_req  = '0;
        bus.m_ack     = 1'b0;
        bus.m_busy    = 1'b0;
        @(negedge clk);
        check("rst_c_busy", bus.c_busy, '0);
        check("rst_c_ack", bus.c_ack, '0);
        check("rst_c_rd_data", bus.c_rd_data, '0);
        check("rst_m_req", {bus.m_wr_req, bus.m_rd_req}, '0);
        check("rst_m_addr", bus.m_addr, '0);
        check("rst_m_wr_data", bus.m_wr_data, '0);
        mp = '0; rr = 0; infl = -1; x_ack = '0; x_iss = 1'b0;
        last_addr = '0; last_wd = '0; cd = -1;
        s_rd = '0; s_wr = '0; inj_ack = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; n_ack = 0; ack_data = '0;
        lat = 3; busy_pct = 0; force_busy = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            s_addr[i] = '0; s_wd[i] = '0; mop[i] = OP_RD;
            ma[i] = '0; md[i] = '0;
        end
        bus.c_addr = '0; bus.c_wr_data = '0; bus.m_rd_data = '0;
        x_rd = '0; x_op = OP_RD; x_addr = '0; x_wd = '0;
        do_reset();

        // single read, memory answers after 3 cycles
        mem[8'h10] = 16'hBEEF;
        s_rd[0] = 1'b1; s_addr[0] = 16'h0010; s_wd[0] = 16'h1111;
        step();
        drain();
        check("sr_acks", n_ack, 1);
        check("sr_data", ack_data, 16'hBEEF);

        // all ports at once from pointer 0
        do_reset();
        iss_q.delete();
        for (int i = 0; i < N; i++) begin
            s_rd[i] = 1'b1; s_addr[i] = AW'(16'h0100 + i);
        end
        step();
        drain();
        check("cont_n", iss_q.size(), N);
        for (int i = 0; i < N && i < iss_q.size(); i++)
            check("cont_order", iss_q[i], 16'h0100 + i);

        // port 2 in flight, then 0 and 3 wait: 3 goes before 0
        iss_q.delete();
        s_rd[2] = 1'b1; s_addr[2] = 16'h0202;
        repeat (3) step();
        s_rd[0] = 1'b1; s_addr[0] = 16'h0200;
        s_rd[3] = 1'b1; s_addr[3] = 16'h0203;
        step();
        drain();
        check("rot_n", iss_q.size(), 3);
        if (iss_q.size() == 3) begin
            check("rot_0", iss_q[0], 16'h0202);
            check("rot_1", iss_q[1], 16'h0203);
            check("rot_2", iss_q[2], 16'h0200);
        end

        // second request on a pending port is dropped
        iss_q.delete();
        s_rd[1] = 1'b1; s_addr[1] = 16'h0301;
        step();
        s_rd[1] = 1'b1; s_addr[1] = 16'h0399;
        step();
        drain();
        check("drop_n", iss_q.size(), 1);
        if (iss_q.size() > 0) check("drop_addr", iss_q[0], 16'h0301);

        // read and write together: write wins
        opq.delete();
        s_rd[2] = 1'b1; s_wr[2] = 1'b1;
        s_addr[2] = 16'h0402; s_wd[2] = 16'h5A5A;
        step();
        drain();
        check("rw_n", opq.size(), 1);
        if (opq.size() > 0) check("rw_op", opq[0], OP_WR);
        s_rd[3] = 1'b1; s_addr[3] = 16'h0402;
        step();
        drain();
        check("rw_readback", ack_data, 16'h5A5A);

        // memory busy holds off the issue
        iss_q.delete();
        force_busy = 1'b1;
        s_rd[1] = 1'b1; s_addr[1] = 16'h0501;
        step();
        repeat (10) step();
        check("bp_held", iss_q.size(), 0);
        force_busy = 1'b0;
        drain();
        check("bp_n", iss_q.size(), 1);

        // reset while waiting, then a stale ack
        s_rd[0] = 1'b1; s_addr[0] = 16'h0600;
        repeat (3) step();
        do_reset();
        inj_ack = 1'b1;
        step();
        step();
        check("late_ack", bus.c_ack, '0);
        iss_q.delete();
        s_rd[3] = 1'b1; s_addr[3] = 16'h0703;
        s_rd[1] = 1'b1; s_addr[1] = 16'h0701;
        step();
        drain();
        check("rst_ptr_n", iss_q.size(), 2);
        if (iss_q.size() > 0) check("rst_ptr_first", iss_q[0], 16'h0701);

        // random traffic
        lat = 0; busy_pct = 25;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                s_addr[i] = AW'($urandom);
                s_wd[i]   = DW'($urandom);
                if ($urandom_range(0, 99) < 15) begin
                    if ($urandom_range(0, 1) == 1) s_wr[i] = 1'b1;
                    else s_rd[i] = 1'b1;
                    if ($urandom_range(0, 7) == 0) s_rd[i] = 1'b1;
                end
            end
            step();
        end
        busy_pct = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin memory arbiter that lets `NUM_PORTS` processor cores share one delayed memory controller (`mem_delayed`), replacing the single-core point-to-point hookup in the computer top level. Each core keeps its existing single-outstanding rd/wr request, busy and ack handshake. The arbiter buffers one request per port, issues them one at a time to memory, and routes the ack and read data back to the originating port.

## Interface
- `NUM_PORTS`, 4: number of client ports, 2..16.
- `ADDR_WIDTH`, 16: address width.
- `DATA_WIDTH`, 16: data width.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `c_rd_req`  in  NUM_PORTS  per-port read request pulse.
- `c_wr_req`  in  NUM_PORTS  per-port write request pulse.
- `c_addr`  in  NUM_PORTS×ADDR_WIDTH  per-port address, sampled with the request.
- `c_wr_data`  in  NUM_PORTS×DATA_WIDTH  per-port write data, sampled with the request.
- `c_busy`  out  NUM_PORTS  port has a request pending.
- `c_ack`  out  NUM_PORTS  one-cycle completion pulse.
- `c_rd_data`  out  NUM_PORTS×DATA_WIDTH  read data, valid while `c_ack` is high.
- `m_rd_req`, `m_wr_req`  out  1  one-cycle request pulses to memory.
- `m_addr`  out  ADDR_WIDTH  memory address.
- `m_wr_data`  out  DATA_WIDTH  memory write data.
- `m_rd_data`  in  DATA_WIDTH  memory read data, valid with `m_ack`.
- `m_busy`  in  1  memory busy.
- `m_ack`  in  1  memory completion pulse.

## Operation
- Per-port pending slot: `pend`, `is_wr`, `addr`, `wdata`.
- A request on port i with `pend[i]=0` captures addr/data at the clock edge and sets `pend[i]`.
- A request on port i with `pend[i]=1` is dropped; the captured request is unchanged.
- `c_wr_req` and `c_rd_req` high together on one port: the write is taken and the read is dropped.
- `c_busy[i] = pend[i]`, registered.
- FSM states: IDLE, WAIT.
- IDLE: if any `pend` is set and `m_busy=0`, grant g = first pending port at or after `rr_ptr`, scanning upward with wrap. At the same edge, drive `m_rd_req` or `m_wr_req` (one-cycle pulse) with `m_addr`/`m_wr_data` from slot g, latch g, and go to WAIT.
- WAIT: on `m_ack`, at that edge:
  - `c_ack[g]=1` for one cycle;
  - `c_rd_data[g]=m_rd_data` for reads, 0 for writes;
  - clear `pend[g]`;
  - `rr_ptr=(g+1) mod NUM_PORTS`;
  - go to IDLE.
- `m_ack` is ignored while in IDLE.
- A new request on port g in the same cycle its `c_ack` is being generated is accepted: the set wins over the clear.
- `m_addr`/`m_wr_data` hold their values from issue until the next issue.
- Reset mid-transaction: all state is cleared. A late `m_ack` arriving after reset hits IDLE and is dropped.
- Reset values:
  - `c_busy`, `c_ack`, `c_rd_data`, `m_rd_req`, `m_wr_req`, `m_addr`, `m_wr_data` = 0;
  - `rr_ptr` = 0; state = IDLE.

## Timing
- Request pulse at cycle t: `c_busy` is high from t+1.
- With memory free and no contention, `m_*_req` is high at t+2.
- `m_ack` at cycle a gives `c_ack` at a+1, and `c_busy` low at a+1.
- Back-to-back issue: the earliest next `m_*_req` is at a+2 (IDLE evaluates at a+1).
- All outputs are registered; there is no combinational path from input to output.
- Fairness: a pending port waits at most NUM_PORTS−1 other transactions.

## Structure
- Package `mem_arb_pkg` holds the FSM state enum (IDLE, WAIT) and the `op_t` enum (OP_RD, OP_WR).
- Sub-module `rr_pick`: combinational; inputs are the pending vector and `rr_ptr`; outputs are grant index and a valid flag. It is parameterised by `NUM_PORTS`.

## Test plan
- Single read: port 0 reads 0x0010, memory returns 0xBEEF after 3 cycles -> `c_ack[0]` at `m_ack`+1 with `c_rd_data[0]=0xBEEF`; `c_busy[0]` spans t+1 up to the ack cycle.
- Contention: ports 0–3 request in the same cycle with `rr_ptr=0` -> issue order 0,1,2,3, with one transaction in flight at a time.
- Rotation: port 2 completes, then ports 0 and 3 are pending -> port 3 is issued before port 0.
- Drop rules:
  - second request on port 1 while pending -> only the first address reaches memory;
  - rd+wr together on one port -> only `m_wr_req` is issued.
- Back-pressure: `m_busy=1` held for 10 cycles with port 1 pending -> no `m_*_req` until `m_busy` drops, then one pulse.
- Reset in WAIT: assert `rst` after issue, deassert, then pulse `m_ack` -> no `c_ack`, all `c_busy=0`, `rr_ptr=0`.
